// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 definitions. Holds the register numbers, the SR
//                and Cause field positions, the handler vector (shared with
//                the next-PC unit) and the sequencer state type.
//  Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers as seen on sel
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // SR / Cause field positions
    localparam int SR_IE_BIT   = 0;
    localparam int SR_EXL_BIT  = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;

    // Fetch redirect target on interrupt entry
    localparam logic [31:0] HANDLER_VECTOR = 32'h0000_3040;

    // Sequencer state: the encoding is the EXL bit itself
    typedef enum logic {
        SEQ_RUN     = 1'b0,
        SEQ_HANDLER = 1'b1
    } seq_state_e;

    // Assemble the architectural SR word from its live fields
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] v;
        v                      = 32'h0;
        v[SR_IM_HI:SR_IM_LO]   = im;
        v[SR_EXL_BIT]          = exl;
        v[SR_IE_BIT]           = ie;
        return v;
    endfunction

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_intctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_intctl_if
//  Description : Pipeline <-> CP0 interrupt controller bundle.
//                master : pipeline side (drives pc, hwint, stall, mtc0/mfc0
//                         controls and eret; receives dout, epc, intreq, exl)
//                slave  : CP0 side
//  Ports       : pc[31:0], hwint[5:0], stall, we, sel[4:0], din[31:0], eret,
//                dout[31:0], epc[29:0], intreq, exl
//  Revision    : 1.0  initial release
// ============================================================================
interface cp0_intctl_if;
    logic [31:0] pc;
    logic [5:0]  hwint;
    logic        stall;
    logic        we;
    logic [4:0]  sel;
    logic [31:0] din;
    logic        eret;
    logic [31:0] dout;
    logic [29:0] epc;
    logic        intreq;
    logic        exl;

    modport master (
        output pc, hwint, stall, we, sel, din, eret,
        input  dout, epc, intreq, exl
    );

    modport slave (
        input  pc, hwint, stall, we, sel, din, eret,
        output dout, epc, intreq, exl
    );
endinterface : cp0_intctl_if
`default_nettype wire

// File: rtl/cp0_intctl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : Count/Compare timer. Count free-runs (wrapping at 2^32);
//                a Count==Compare match sets a sticky pending flag which a
//                Compare write clears. With TIMER_EN=0 Count is held at 0
//                and the pending flag never sets.
//  Ports       : clk, rst           clock, async active-high reset
//                cnt_we_i           write Count from wdata_i
//                cmp_we_i           write Compare from wdata_i
//                wdata_i[31:0]      write data
//                count_o, compare_o register values for mfc0
//                pend_o             timer interrupt pending
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_timer #(
    parameter bit TIMER_EN = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        cnt_we_i,
    input  wire logic        cmp_we_i,
    input  wire logic [31:0] wdata_i,
    output logic      [31:0] count_o,
    output logic      [31:0] compare_o,
    output logic             pend_o
);

    logic [31:0] compare_q;

    // Compare is writable regardless of TIMER_EN so software sees a normal register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q <= 32'hFFFF_FFFF;
        end else if (cmp_we_i) begin
            compare_q <= wdata_i;
        end
    end

    assign compare_o = compare_q;

    generate
        if (TIMER_EN) begin : g_timer_on
            logic [31:0] count_q, count_d;
            logic        pend_q,  pend_d;
            logic        w_match;

            // Match is on the current (pre-write) Count value
            assign w_match = (count_q == compare_q);

            always_comb begin
                count_d = cnt_we_i ? wdata_i : count_q + 32'd1;
                pend_d  = pend_q;
                if (cmp_we_i) begin
                    pend_d = 1'b0;      // clear beats a same-cycle match
                end else if (w_match) begin
                    pend_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= 32'h0;
                    pend_q  <= 1'b0;
                end else begin
                    count_q <= count_d;
                    pend_q  <= pend_d;
                end
            end

            assign count_o = count_q;
            assign pend_o  = pend_q;
        end else begin : g_timer_off
            logic w_unused_cnt_we;
            assign w_unused_cnt_we = cnt_we_i;
            assign count_o         = 32'h0;
            assign pend_o          = 1'b0;
        end
    endgenerate

endmodule : cp0_timer
`default_nettype wire

// File: rtl/cp0_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_intctl
//  Description : Coprocessor-0 interrupt controller. Holds SR, Cause, EPC,
//                PRId and (via cp0_timer) Count/Compare; services mtc0/mfc0;
//                merges six hardware lines with the timer and raises intreq
//                on the cycle the fetch path must jump to the handler.
//  Ports       : clk, rst   clock, asynchronous active-high reset
//                bus        cp0_intctl_if.slave:
//                  in : pc, hwint, stall, we, sel, din, eret
//                  out: dout (mfc0 data), epc (EPC[31:2]), intreq, exl
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_intctl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h4D49_5053,
    parameter bit          TIMER_EN = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cp0_intctl_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e  state_q, state_d;
    logic [5:0]  im_q,    im_d;
    logic        ie_q,    ie_d;
    logic [5:0]  ip_q,    ip_d;
    logic [29:0] epc_q,   epc_d;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_tmr_pend;
    logic        w_intreq;
    logic        w_wr_sr;
    logic        w_wr_epc;

    assign w_wr_sr  = bus.we && (bus.sel == CP0_SR);
    assign w_wr_epc = bus.we && (bus.sel == CP0_EPC);

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    cp0_timer #(
        .TIMER_EN (TIMER_EN)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt_we_i  (bus.we && (bus.sel == CP0_COUNT)),
        .cmp_we_i  (bus.we && (bus.sel == CP0_COMPARE)),
        .wdata_i   (bus.din),
        .count_o   (w_count),
        .compare_o (w_compare),
        .pend_o    (w_tmr_pend)
    );

    // ------------------------------------------------------------------
    // Interrupt request: purely from registered state plus the two
    // pipeline qualifiers, so the next-PC unit sees it this same cycle.
    // ------------------------------------------------------------------
    assign w_intreq = (|(ip_q & im_q)) && ie_q && (state_q == SEQ_RUN)
                      && !bus.stall && !bus.eret;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        ie_d    = ie_q;
        epc_d   = epc_q;

        // Cause.IP tracks the lines with one register stage
        ip_d = {bus.hwint[5] | w_tmr_pend, bus.hwint[4:0]};

        if (w_wr_sr) begin
            im_d    = bus.din[SR_IM_HI:SR_IM_LO];
            ie_d    = bus.din[SR_IE_BIT];
            state_d = seq_state_e'(bus.din[SR_EXL_BIT]);
        end

        // Sequencer events override a software write of EXL / EPC.
        // intreq excludes eret, so these two never coincide.
        if (w_intreq) begin
            state_d = SEQ_HANDLER;
        end else if (bus.eret && (state_q == SEQ_HANDLER)) begin
            state_d = SEQ_RUN;
        end

        if (w_intreq) begin
            epc_d = bus.pc[31:2];
        end else if (w_wr_epc) begin
            epc_d = bus.din[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_RUN;
            im_q    <= 6'h0;
            ie_q    <= 1'b0;
            ip_q    <= 6'h0;
            epc_q   <= 30'h0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            ie_q    <= ie_d;
            ip_q    <= ip_d;
            epc_q   <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // mfc0 read mux (zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        bus.dout = 32'h0;
        case (bus.sel)
            CP0_COUNT:   bus.dout = w_count;
            CP0_COMPARE: bus.dout = w_compare;
            CP0_SR:      bus.dout = pack_sr(im_q, state_q == SEQ_HANDLER, ie_q);
            CP0_CAUSE:   bus.dout[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
            CP0_EPC:     bus.dout = {epc_q, 2'b00};
            CP0_PRID:    bus.dout = PRID;
            default:     bus.dout = 32'h0;
        endcase
    end

    assign bus.intreq = w_intreq;
    assign bus.epc    = epc_q;
    assign bus.exl    = (state_q == SEQ_HANDLER);

    // Low pc bits and non-field SR bits carry no state here
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.pc[1:0], bus.din[1:0], bus.din[9:2], bus.din[31:16]};

endmodule : cp0_intctl
`default_nettype wire

// File: tb/tb_cp0_intctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_intctl
//  Description : Self-checking bench for cp0_intctl. A register-level model
//                of the CP0 state is compared with the DUT every cycle;
//                directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_intctl;

    logic clk;
    logic rst;

    cp0_intctl_if bus ();

    cp0_intctl #(
        .PRID     (32'h4D49_5053),
        .TIMER_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // ---------------- model state ----------------
    logic [5:0]  m_im;
    logic        m_ie;
    logic        m_exl;
    logic [5:0]  m_ip;
    logic [29:0] m_epc;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_im = 6'h0; m_ie = 1'b0; m_exl = 1'b0; m_ip = 6'h0; m_epc = 30'h0;
        m_count = 32'h0; m_compare = 32'hFFFF_FFFF; m_pend = 1'b0;
    endtask

    function automatic logic model_intreq();
        return ((m_ip & m_im) != 6'h0) && m_ie && !m_exl && !bus.stall && !bus.eret;
    endfunction

    function automatic logic [31:0] model_dout(input logic [4:0] s);
        case (s)
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13: return {16'h0, m_ip, 10'h0};
            5'd14: return {m_epc, 2'b00};
            5'd15: return 32'h4D49_5053;
            default: return 32'h0;
        endcase
    endfunction

    // Compare all outputs against the model; call #1 after inputs settle
    task automatic settle();
        #1;
        chk("intreq", {31'h0, bus.intreq}, {31'h0, model_intreq()});
        chk("exl",    {31'h0, bus.exl},    {31'h0, m_exl});
        chk("epc",    {2'b0, bus.epc},     {2'b0, m_epc});
        chk("dout",   bus.dout,            model_dout(bus.sel));
    endtask

    // Apply one clock edge to the model and move to the next negedge
    task automatic adv();
        logic        take;
        logic        match;
        logic        wr_cnt, wr_cmp, wr_sr, wr_epc;
        take   = model_intreq();
        match  = (m_count == m_compare);
        wr_cnt = bus.we && bus.sel == 5'd9;
        wr_cmp = bus.we && bus.sel == 5'd11;
        wr_sr  = bus.we && bus.sel == 5'd12;
        wr_epc = bus.we && bus.sel == 5'd14;

        m_ip = {bus.hwint[5] | m_pend, bus.hwint[4:0]};
        if (wr_cmp)     m_pend = 1'b0;
        else if (match) m_pend = 1'b1;
        m_count = wr_cnt ? bus.din : m_count + 32'd1;
        if (wr_cmp) m_compare = bus.din;
        if (wr_sr) begin
            m_im = bus.din[15:10];
            m_ie = bus.din[0];
        end
        if (take)                   m_exl = 1'b1;
        else if (bus.eret && m_exl) m_exl = 1'b0;
        else if (wr_sr)             m_exl = bus.din[1];
        if (take)        m_epc = bus.pc[31:2];
        else if (wr_epc) m_epc = bus.din[31:2];
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic idle_inputs();
        bus.we = 1'b0; bus.eret = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic write(input logic [4:0] s, input logic [31:0] d);
        bus.we = 1'b1; bus.sel = s; bus.din = d;
        tick();
        bus.we = 1'b0;
    endtask

    // Leave the handler cleanly (lines dropped, then eret)
    task automatic drain();
        idle_inputs();
        bus.hwint = 6'h0;
        tick();
        tick();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        tick();
    endtask

    initial begin
        logic [4:0]  rd_sel [6];
        logic [31:0] rd_exp [6];
        bit          seen;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.pc = 32'h0; bus.hwint = 6'h0; bus.stall = 1'b0; bus.we = 1'b0;
        bus.sel = 5'd0; bus.din = 32'h0; bus.eret = 1'b0;
        model_reset();

        // ---------------- reset values (literal) ----------------
        rd_sel = '{5'd12, 5'd13, 5'd14, 5'd9, 5'd11, 5'd15};
        rd_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h4D49_5053};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.sel = rd_sel[i];
            #1;
            chk("reset_read", bus.dout, rd_exp[i]);
        end
        chk("reset_intreq", {31'h0, bus.intreq}, 32'h0);
        chk("reset_exl",    {31'h0, bus.exl},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.sel = 5'd12;

        // ---------------- hwint[0] entry / eret ----------------
        write(5'd12, 32'h0000_0401);
        bus.hwint = 6'h01; bus.pc = 32'h0000_3008;
        tick();
        settle();
        chk("hw_intreq_on", {31'h0, bus.intreq}, 32'h1);
        adv();
        settle();
        chk("hw_intreq_pulse", {31'h0, bus.intreq}, 32'h0);
        chk("hw_exl", {31'h0, bus.exl}, 32'h1);
        chk("hw_epc", {2'b0, bus.epc}, 32'h0000_0C02);
        adv();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        settle();
        chk("eret_exl", {31'h0, bus.exl}, 32'h0);
        chk("eret_reassert", {31'h0, bus.intreq}, 32'h1);
        adv();
        drain();

        // ---------------- stall holds off entry ----------------
        bus.hwint = 6'h01; bus.stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.pc = 32'h0000_4000 + 32'(i * 4);
            settle();
            chk("stall_block", {31'h0, bus.intreq}, 32'h0);
            adv();
        end
        bus.stall = 1'b0; bus.pc = 32'h0000_4010;
        settle();
        chk("stall_release", {31'h0, bus.intreq}, 32'h1);
        adv();
        settle();
        chk("stall_epc", {2'b0, bus.epc}, 32'h0000_1004);
        adv();
        drain();

        // ---------------- timer ----------------
        write(5'd11, 32'd5);
        write(5'd9,  32'd0);
        write(5'd12, 32'h0000_8001);
        bus.sel = 5'd13;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            settle();
            seen = bus.intreq;
            adv();
        end
        chk("timer_intreq_seen", {31'h0, seen}, 32'h1);
        bus.sel = 5'd13;
        settle();
        chk("timer_ip15", bus.dout, 32'h0000_8000);
        adv();
        write(5'd11, 32'hFFFF_FFF0);
        tick();
        bus.sel = 5'd13;
        settle();
        chk("timer_cleared", bus.dout, 32'h0);
        adv();
        drain();

        // ---------------- simultaneous writes with entry ----------------
        write(5'd12, 32'h0000_0401);
        bus.hwint = 6'h01;
        tick();
        bus.we = 1'b1; bus.sel = 5'd14; bus.din = 32'hDEAD_BEEF; bus.pc = 32'h0000_5000;
        settle();
        chk("epcw_intreq", {31'h0, bus.intreq}, 32'h1);
        adv();
        bus.we = 1'b0;
        settle();
        chk("epcw_epc", {2'b0, bus.epc}, 32'h0000_1400);
        adv();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.we = 1'b1; bus.sel = 5'd12; bus.din = 32'h0;
        settle();
        chk("srw_intreq", {31'h0, bus.intreq}, 32'h1);
        adv();
        bus.we = 1'b0;
        settle();
        chk("srw_sr", bus.dout, 32'h0000_0002);
        adv();
        drain();

        // ---------------- randomized ----------------
        for (int n = 0; n < 3000; n++) begin
            bus.hwint = 6'($urandom_range(0, 3) == 0 ? $urandom : 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.eret  = ($urandom_range(0, 7) == 0);
            bus.pc    = $urandom;
            bus.we    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: bus.sel = 5'd9;
                1: bus.sel = 5'd11;
                2, 3: bus.sel = 5'd12;
                4: bus.sel = 5'd13;
                5: bus.sel = 5'd14;
                6: bus.sel = 5'd15;
                default: bus.sel = 5'($urandom);
            endcase
            bus.din = $urandom;
            if (bus.sel == 5'd9)  bus.din = m_compare - 32'($urandom_range(0, 6));
            if (bus.sel == 5'd11) bus.din = m_count + 32'($urandom_range(0, 12));
            if (bus.sel == 5'd12 && $urandom_range(0, 1) == 1) bus.din = bus.din | 32'h1;
            tick();
        end

        // ---------------- asynchronous reset mid-handler ----------------
        idle_inputs();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        write(5'd12, 32'h0000_0401);
        bus.hwint = 6'h01; bus.pc = 32'h0000_7004;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = m_exl;
        end
        chk("pre_rst_exl", {31'h0, bus.exl}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_exl",    {31'h0, bus.exl},    32'h0);
        chk("arst_epc",    {2'b0, bus.epc},     32'h0);
        chk("arst_intreq", {31'h0, bus.intreq}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.hwint = 6'h0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_cp0_intctl
`default_nettype wire

// File: doc/cp0_intctl.md
# cp0_intctl

Coprocessor-0 interrupt controller that drives the next-PC unit's `intreq`, `epc` and exception-return sequencing. It holds SR, Cause, EPC, PRId, Count and Compare, and services `mtc0`/`mfc0` accesses. It merges six external hardware interrupt lines with an internal Count/Compare timer. It decides on which cycle the fetch path is redirected to the handler vector 32'h0000_3040.

## Interface
- `PRID`, 32'h4D49_5053, read-only value of PRId (reg 15)
- `TIMER_EN`, 1, 1 = Count/Compare timer drives IP[15]; 0 = Count frozen at 0, IP[15] = hwint[5] only

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  32  address of the next instruction to execute (resume point)
- `hwint`  in  6  level-sensitive device interrupts, hwint[i] maps to IP[10+i]
- `stall`  in  1  pipeline not at an instruction boundary; suppresses interrupt entry
- `we`  in  1  `mtc0` write strobe
- `sel`  in  5  CP0 register number for `mtc0`/`mfc0`
- `din`  in  32  `mtc0` write data
- `eret`  in  1  ERET executing this cycle
- `dout`  out  32  `mfc0` read data, combinational on `sel`
- `epc`  out  30  EPC[31:2] to next-PC unit
- `intreq`  out  1  take interrupt this cycle (next-PC selects handler vector)
- `exl`  out  1  SR.EXL, handler-in-progress flag

## Operation
- Register map: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId; other `sel` values read 0, writes ignored.
- SR fields: IM[15:10], EXL[1], IE[0]; other bits read 0. Cause: IP[15:10] read-only, all other bits 0.
- IP[15:10] = {hwint[5] | tmr_pend, hwint[4:0]}, sampled into the Cause register every cycle (visible in `dout` one cycle after the line changes).
- `intreq` = |(Cause.IP & SR.IM) & IE & !EXL & !stall & !eret. It is combinational from registered state.
- Two-state sequencer encoded by EXL:
  - RUN -> HANDLER on a cycle with `intreq`=1: EPC <= pc[31:2], EXL <= 1.
  - HANDLER -> RUN on `eret`=1: EXL <= 0. `eret` in RUN is ignored.
- Timer (when `TIMER_EN`=1):
  - Count += 1 every cycle, wrapping at 2^32.
  - When Count == Compare, tmr_pend <= 1. tmr_pend is sticky.
  - Writing Compare clears tmr_pend.
- Writes: `mtc0` to Count, Compare, SR or EPC updates the register at the edge. Writes to Cause and PRId are ignored.
- Reset: SR=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, tmr_pend=0, so `intreq`=0, `epc`=0, `exl`=0, `dout` = value of the register selected by `sel`.

## Timing
- Interrupt entry: the cycle with `intreq`=1 is the redirect cycle, and EXL=1 from the next edge. `intreq` is therefore a one-cycle pulse per entry.
- `mfc0` has zero latency. A write is visible in `dout` the cycle after `we`.
- Simultaneous events:
  - `we` to SR with entry: IM/IE take `din`, but EXL is forced to 1.
  - `we` to EPC with entry: entry wins, EPC <= pc[31:2].
  - `we` to SR with `eret`: EXL <= 0, other fields from `din`.
  - `we` to Count on a match cycle: the match on the old Count still sets tmr_pend, and Count takes `din` (no increment).
  - `we` to Compare on a match cycle: the clear wins, tmr_pend=0.
- A hwint pulse shorter than one cycle may be lost. Devices must hold the line until acknowledged.
- `rst` asserted mid-handler returns to RUN immediately (asynchronous). EPC is cleared.

## Structure
- Package `cp0_pkg`: register numbers (CP0_COUNT=9 … CP0_PRID=15), SR/Cause bit positions, handler vector 32'h0000_3040 (shared with next-PC unit).
- One sub-module, `cp0_timer`: Count/Compare/tmr_pend with write ports and match logic. The remaining registers and the sequencer live in the top level.

## Test plan
- Reset, then read every `sel`: SR=0, Cause=0, EPC=0, Count=0, Compare=FFFF_FFFF, PRId=4D49_5053.
- Write SR=32'h0000_0401 (IM[10], IE), raise hwint[0], pc=32'h0000_3008 → `intreq`=1 for exactly one cycle, then `exl`=1 and `epc`=30'h0000_0C02. Then `eret` → `exl`=0, and `intreq` reasserts next cycle if hwint[0] is still high.
- Same setup with `stall`=1 for 3 cycles → `intreq`=0 throughout. Release `stall` → entry occurs, and EPC captures `pc` of the release cycle.
- Write Compare=5 and Count=0, SR=32'h0000_8001 → tmr_pend set when Count reaches 5 and `intreq` pulses. Write Compare → pend clears and Cause.IP[15]=0.
- Entry cycle coinciding with `we` to EPC (din=32'hDEAD_BEEF) → EPC=pc[31:2] and not din. Entry with `we` to SR din=0 → `exl`=1, IE=0.
- Assert `rst` while `exl`=1 → `exl`, `epc`, `intreq` go to 0 without waiting for a clock edge.
